// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: circular sample delay line and coefficient file feeding the mac stage.
// Define FIR_COEF_WRITE_EN for a writable coefficient file; otherwise every coefficient is 1.
module fir_tap_sequencer #(
    parameter  int N    = 8,
    parameter  int TAPS = 8,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_sample,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_wdata,
    output logic [N-1:0]  a,
    output logic [N-1:0]  b,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  dline [TAPS];
    logic [AW-1:0] wptr;
    logic [AW-1:0] wptr_inc;
    logic [AW-1:0] base;
    logic [AW-1:0] i;
    logic [AW-1:0] nxt;
    logic [AW-1:0] rd_idx;
    logic [AW:0]   base_w;
    logic [AW:0]   nxt_w;
    logic [AW:0]   idx_w;
    logic          accept;
    logic          last_tap;
    logic [N-1:0]  coef_rd;
    logic [N-1:0]  coef_first;

    // Next tap index and its delay-line slot, wrapped by compare-and-add.
    always_comb begin
        nxt    = i + AW'(1);
        base_w = {1'b0, base};
        nxt_w  = {1'b0, nxt};
        if (base_w >= nxt_w) begin
            idx_w = base_w - nxt_w;
        end else begin
            idx_w = base_w + (AW+1)'(TAPS) - nxt_w;
        end
        rd_idx = idx_w[AW-1:0];
        if (wptr == AW'(TAPS - 1)) begin
            wptr_inc = '0;
        end else begin
            wptr_inc = wptr + AW'(1);
        end
    end

    // FSM next state: one sample accepted in IDLE, TAPS pairs streamed in RUN.
    always_comb begin
        state_nxt = state;
        accept    = (state == IDLE) && in_valid && in_ready;
        last_tap  = (i == AW'(TAPS - 1));
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (last_tap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Delay line, pointers and registered MAC operands; tap 0 is the sample just taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            base     <= '0;
            i        <= '0;
            in_ready <= 1'b0;
            a        <= '0;
            b        <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dline[k] <= '0;
            end
        end else begin
            in_ready <= (state_nxt == IDLE);
            a        <= '0;
            b        <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dline[wptr] <= in_sample;
                        base        <= wptr;
                        wptr        <= wptr_inc;
                        i           <= '0;
                        a           <= in_sample;
                        b           <= coef_first;
                        mac_en      <= 1'b1;
                        mac_clr     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!last_tap) begin
                        i        <= nxt;
                        a        <= dline[rd_idx];
                        b        <= coef_rd;
                        mac_en   <= 1'b1;
                        mac_last <= (nxt == AW'(TAPS - 1));
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIR_COEF_WRITE_EN
    logic [N-1:0] coef [TAPS];
    logic         coef_wr;

    // Writes land only while idle so an output always sees one coefficient set.
    always_comb begin
        coef_wr = (state == IDLE) && coef_we &&
                  ({1'b0, coef_addr} < (AW+1)'(TAPS));
    end

    // Coefficient register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
            end
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Coefficient reads; a write to entry 0 on the accept edge is forwarded to tap 0.
    always_comb begin
        coef_rd = coef[nxt];
        if (coef_wr && coef_addr == '0) begin
            coef_first = coef_wdata;
        end else begin
            coef_first = coef[0];
        end
    end
`else
    logic unused_coef;

    // Moving-sum filter: every coefficient is the constant 1.
    always_comb begin
        coef_rd     = N'(1);
        coef_first  = N'(1);
        unused_coef = ^{coef_we, coef_addr, coef_wdata};
    end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed stimulus with a per-cycle behavioural model.
// Coefficient expectations follow FIR_COEF_WRITE_EN when it is defined.
module tb_fir_tap_sequencer;
    localparam int N    = 8;
    localparam int TAPS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_sample = '0;
    logic       coef_we = 1'b0;
    logic [1:0] coef_addr = '0;
    logic [7:0] coef_wdata = '0;
    logic [7:0] a;
    logic [7:0] b;
    logic       mac_en;
    logic       mac_clr;
    logic       mac_last;

    fir_tap_sequencer #(.N(N), .TAPS(TAPS)) dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .a(a), .b(b), .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int clr;
        int last;
    } pair_t;

    pair_t cap[$];
    int    acc[$];

    // Behavioural model: history of accepted samples and a tap count per output.
    int       hist[$];
    int       mcoef[TAPS];
    int       m_tap = -1;
    int       m_ready = 0;
    int       e_a = 0, e_b = 0, e_en = 0, e_clr = 0, e_last = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int n;
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < TAPS; k++) begin
`ifdef FIR_COEF_WRITE_EN
                mcoef[k] = 0;
`else
                mcoef[k] = 1;
`endif
            end
            m_tap = -1;
            m_ready = 0;
        end else if (m_tap >= 0) begin
            m_tap = m_tap + 1;
            if (m_tap == TAPS) begin
                m_tap = -1;
                m_ready = 1;
            end
        end else begin
`ifdef FIR_COEF_WRITE_EN
            if (coef_we && int'(coef_addr) < TAPS) mcoef[coef_addr] = int'(coef_wdata);
`endif
            if (in_valid && m_ready == 1) begin
                hist.push_back(int'(in_sample));
                m_tap = 0;
                m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end
        e_a = 0; e_b = 0; e_en = 0; e_clr = 0; e_last = 0;
        if (m_tap >= 0) begin
            n = hist.size() - 1;
            e_a = (n - m_tap >= 0) ? hist[n - m_tap] : 0;
            e_b = mcoef[m_tap];
            e_en = 1;
            e_clr = (m_tap == 0) ? 1 : 0;
            e_last = (m_tap == TAPS - 1) ? 1 : 0;
        end
    end

    // Per-cycle comparison against the model, plus capture of pairs and accepts.
    always @(negedge clk) begin
        checks = checks + 1;
        if (int'(a) != e_a || int'(b) != e_b || int'(mac_en) != e_en ||
            int'(mac_clr) != e_clr || int'(mac_last) != e_last ||
            int'(in_ready) != m_ready) begin
            errors = errors + 1;
            $display("FAIL model cyc=%0d got a=%0d b=%0d en=%0d clr=%0d last=%0d rdy=%0d want a=%0d b=%0d en=%0d clr=%0d last=%0d rdy=%0d",
                     cyc, a, b, mac_en, mac_clr, mac_last, in_ready,
                     e_a, e_b, e_en, e_clr, e_last, m_ready);
        end
        if (mac_en) cap.push_back('{int'(a), int'(b), int'(mac_clr), int'(mac_last)});
        if (in_valid && in_ready) acc.push_back(cyc);
    end

    function automatic int eb(input int v);
`ifdef FIR_COEF_WRITE_EN
        return v;
`else
        return (v >= 0) ? 1 : 1;
`endif
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int adr, input int val);
        coef_we = 1'b1;
        coef_addr = 2'(adr);
        coef_wdata = 8'(val);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic load_coefs();
        for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
    endtask

    task automatic send(input int x, input bit keep);
        int t = 0;
        in_sample = 8'(x);
        in_valid = 1'b1;
        while (!in_ready && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) chk("send_timeout", t, 0);
        tick();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) chk("idle_timeout", t, 0);
    endtask

    task automatic wait_cap(input int n);
        int t = 0;
        while (cap.size() < n && t < 80) begin
            tick();
            t++;
        end
    endtask

    task automatic check_pairs(input string nm, input int off, input int ea[4]);
        if (cap.size() < off + 4) begin
            chk({nm, "_count"}, cap.size(), off + 4);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_a%0d", nm, k), cap[off+k].a, ea[k]);
            chk($sformatf("%s_b%0d", nm, k), cap[off+k].b, eb(k + 1));
            chk($sformatf("%s_clr%0d", nm, k), cap[off+k].clr, (k == 0) ? 1 : 0);
            chk($sformatf("%s_last%0d", nm, k), cap[off+k].last, (k == 3) ? 1 : 0);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_a"}, int'(a), 0);
        chk({nm, "_b"}, int'(b), 0);
        chk({nm, "_en"}, int'(mac_en), 0);
        chk({nm, "_clr"}, int'(mac_clr), 0);
        chk({nm, "_last"}, int'(mac_last), 0);
        chk({nm, "_rdy"}, int'(in_ready), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", int'(in_ready), 1);

        load_coefs();
        cap.delete();
        send(2, 1'b0);
        wait_cap(4);
        check_pairs("first", 0, '{2, 0, 0, 0});

        wait_idle();
        cap.delete();
        acc.delete();
        send(3, 1'b1);
        send(6, 1'b0);
        wait_cap(8);
        check_pairs("b2b_3", 0, '{3, 2, 0, 0});
        check_pairs("b2b_6", 4, '{6, 3, 2, 0});
        if (acc.size() >= 2) chk("accept_gap", acc[1] - acc[0], 5);
        else chk("accept_count", acc.size(), 2);

        wait_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load_coefs();
        cap.delete();
        for (int k = 1; k <= 4; k++) send(k, 1'b1);
        send(5, 1'b0);
        wait_cap(20);
        check_pairs("wrap", 16, '{5, 4, 3, 2});

        wait_idle();
        cap.delete();
        send(6, 1'b0);
        tick();
        wr_coef(0, 9);
        wait_idle();
        cap.delete();
        send(7, 1'b0);
        wait_cap(4);
        if (cap.size() >= 1) begin
            chk("run_write_a", cap[0].a, 7);
            chk("run_write_b", cap[0].b, eb(1));
        end else chk("run_write_count", cap.size(), 1);
        wait_idle();
        wr_coef(0, 9);
        cap.delete();
        send(8, 1'b0);
        wait_cap(4);
        if (cap.size() >= 1) begin
            chk("idle_write_a", cap[0].a, 8);
            chk("idle_write_b", cap[0].b, eb(9));
        end else chk("idle_write_count", cap.size(), 1);

        wait_idle();
        send(5, 1'b0);
        tick();
        tick();
        chk("pre_reset_en", int'(mac_en), 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        tick();
        tick();
        rst_n = 1'b1;
        load_coefs();
        cap.delete();
        send(7, 1'b0);
        wait_cap(4);
        check_pairs("after_reset", 0, '{7, 0, 0, 0});

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
